cep_delta_ring_writer: RTL and testbench

- Write side of the cepstral-to-delta frame ring buffer.
- Accepts cepstral coefficients from the DCT/lifter stage over a valid/ready handshake.
- Writes them frame-by-frame into a FRAME_NUM-deep circular buffer and tracks complete stored frames.
- The delta stage's loop counter reads frames and returns them through a release pulse; this block produces the matching write addresses and back-pressure.

---
 rtl/cep_delta_pkg.sv | 20 ++
 rtl/cep_ring_addr_gen.sv | 73 +++++++
 rtl/cep_delta_ring_writer.sv | 184 ++++++++++++++++++
 tb/tb_cep_delta_ring_writer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cep_delta_pkg.sv
// Shared definitions for the cepstral-to-delta frame ring buffer.
// Used by the ring writer, the delta reader and the reader's loop counter.
// Contents: geometry constants, coefficient data type, writer FSM state enum.
package cep_delta_pkg;

  localparam int unsigned DATA_WIDTH = 16;  // coefficient width
  localparam int unsigned COEF_NUM   = 13;  // coefficients per frame
  localparam int unsigned FRAME_NUM  = 5;   // frames in the ring (delta window t-2..t+2)
  localparam int unsigned ADDR_WIDTH = 7;   // must hold FRAME_NUM*COEF_NUM
  localparam int unsigned FCNT_WIDTH = 3;   // must hold FRAME_NUM
  localparam int unsigned PAD_FRAMES = 2;   // zero frames appended on end-of-utterance flush

  typedef logic [DATA_WIDTH-1:0] coef_t;

  typedef enum logic [0:0] {
    S_WRITE = 1'b0,
    S_PAD   = 1'b1
  } wr_state_e;

endpackage

// File: rtl/cep_ring_addr_gen.sv
// Ring address generator for the cepstral frame buffer.
// Tracks coefficient index, frame slot pointer and the frame base address
// (slot * CoefNum, built by accumulation so no multiplier is needed).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   advance_i      one coefficient slot is consumed this cycle
//   addr_o         current write address (base + coefficient index)
//   last_coef_o    current index is the last coefficient of a frame
//   frame_wrap_o   current index is the last coefficient of the last slot
//   mid_frame_o    a frame is partially written (index != 0)
module cep_ring_addr_gen
  import cep_delta_pkg::*;
#(
  parameter int unsigned CoefNum   = COEF_NUM,
  parameter int unsigned FrameNum  = FRAME_NUM,
  parameter int unsigned AddrWidth = ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 advance_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 last_coef_o,
  output logic                 frame_wrap_o,
  output logic                 mid_frame_o
);

  localparam int unsigned CntW = (CoefNum > 1) ? $clog2(CoefNum) : 1;
  localparam int unsigned PtrW = (FrameNum > 1) ? $clog2(FrameNum) : 1;

  logic [CntW-1:0]      coef_cnt_q, coef_cnt_d;
  logic [PtrW-1:0]      frame_ptr_q, frame_ptr_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic                 last_slot;

  assign last_slot    = (frame_ptr_q == PtrW'(FrameNum - 1));
  assign last_coef_o  = (coef_cnt_q == CntW'(CoefNum - 1));
  assign frame_wrap_o = last_coef_o && last_slot;
  assign mid_frame_o  = (coef_cnt_q != '0);
  assign addr_o       = base_q + AddrWidth'(coef_cnt_q);

  always_comb begin
    coef_cnt_d  = coef_cnt_q;
    frame_ptr_d = frame_ptr_q;
    base_d      = base_q;
    if (advance_i) begin
      if (last_coef_o) begin
        coef_cnt_d = '0;
        if (last_slot) begin
          frame_ptr_d = '0;
          base_d      = '0;
        end else begin
          frame_ptr_d = frame_ptr_q + PtrW'(1);
          base_d      = base_q + AddrWidth'(CoefNum);
        end
      end else begin
        coef_cnt_d = coef_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_cnt_q  <= '0;
      frame_ptr_q <= '0;
      base_q      <= '0;
    end else begin
      coef_cnt_q  <= coef_cnt_d;
      frame_ptr_q <= frame_ptr_d;
      base_q      <= base_d;
    end
  end

endmodule

// File: rtl/cep_delta_ring_writer.sv
// Write side of the cepstral-to-delta frame ring buffer.
// Accepts coefficients over valid/ready, writes them frame by frame into a
// FrameNum-deep ring and counts complete frames; the delta reader returns
// frames with rd_frame_release_i.
// Optional end-of-utterance zero padding is built when CEP_DELTA_PAD_EN is
// defined; otherwise eou_flush_i is ignored and eou_done_o stays 0.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cep_valid_i/cep_data_i/cep_ready_o  coefficient handshake
//   rd_frame_release_i               oldest frame consumed (pulse)
//   eou_flush_i                      end-of-utterance request (pulse)
//   mem_wr_en_o/addr_o/data_o        registered buffer write port
//   frame_done_o                     pulse with the last write of a frame
//   frame_count_o, full_o            complete frames held / ring full
//   eou_done_o                       pulse with the last padding write
module cep_delta_ring_writer
  import cep_delta_pkg::*;
#(
  parameter int unsigned DataWidth  = DATA_WIDTH,
  parameter int unsigned CoefNum    = COEF_NUM,
  parameter int unsigned FrameNum   = FRAME_NUM,
  parameter int unsigned AddrWidth  = ADDR_WIDTH,
  parameter int unsigned FcntWidth  = FCNT_WIDTH,
  parameter int unsigned PadFrames  = PAD_FRAMES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cep_valid_i,
  input  logic [DataWidth-1:0] cep_data_i,
  output logic                 cep_ready_o,
  input  logic                 rd_frame_release_i,
  input  logic                 eou_flush_i,
  output logic                 mem_wr_en_o,
  output logic [AddrWidth-1:0] mem_wr_addr_o,
  output logic [DataWidth-1:0] mem_wr_data_o,
  output logic                 frame_done_o,
  output logic [FcntWidth-1:0] frame_count_o,
  output logic                 full_o,
  output logic                 eou_done_o
);

  wr_state_e            state_q, state_d;
  logic                 init_q;  // keeps cep_ready_o low while in reset
  logic                 accept, pad_wr, advance;
  logic                 last_coef, mid_frame, unused_wrap;
  logic [AddrWidth-1:0] addr;
  logic                 frame_inc, frame_dec, eou_done_d;
  logic [FcntWidth-1:0] frame_count_q, frame_count_d;
  logic                 wr_en_q, frame_done_q, eou_done_q;
  logic [AddrWidth-1:0] wr_addr_q;
  logic [DataWidth-1:0] wr_data_q;

  assign full_o = (frame_count_q == FcntWidth'(FrameNum));

  // Output decode: depends on registered state only, never on cep_valid_i.
  always_comb begin
    cep_ready_o = init_q && (state_q == S_WRITE) && !full_o;
    pad_wr      = (state_q == S_PAD) && !full_o;
  end

  assign accept  = cep_valid_i && cep_ready_o;
  assign advance = accept || pad_wr;

  cep_ring_addr_gen #(
    .CoefNum  (CoefNum),
    .FrameNum (FrameNum),
    .AddrWidth(AddrWidth)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance_i   (advance),
    .addr_o      (addr),
    .last_coef_o (last_coef),
    .frame_wrap_o(unused_wrap),
    .mid_frame_o (mid_frame)
  );

`ifdef CEP_DELTA_PAD_EN
  localparam int unsigned PadW = $clog2(PadFrames + 2);

  logic [PadW-1:0] pad_left_q, pad_left_d, pad_total;
  logic            partial_next, flush_req, pad_last;

  // Frame state after this cycle's transfer decides whether the flush must
  // first complete a partial frame.
  assign partial_next = accept ? !last_coef : mid_frame;
  assign pad_total    = PadW'(PadFrames) + PadW'(partial_next);
  assign flush_req    = (state_q == S_WRITE) && eou_flush_i;
  assign pad_last     = pad_wr && last_coef && (pad_left_q == PadW'(1));

  always_comb begin
    state_d    = state_q;
    pad_left_d = pad_left_q;
    eou_done_d = 1'b0;
    unique case (state_q)
      S_WRITE: begin
        if (flush_req) begin
          pad_left_d = pad_total;
          if (pad_total != '0) begin
            state_d = S_PAD;
          end else begin
            eou_done_d = 1'b1;  // nothing to pad
          end
        end
      end
      S_PAD: begin
        if (pad_wr && last_coef) begin
          pad_left_d = pad_left_q - PadW'(1);
        end
        if (pad_last) begin
          state_d    = S_WRITE;
          eou_done_d = 1'b1;
        end
      end
      default: state_d = S_WRITE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_left_q <= '0;
    end else begin
      pad_left_q <= pad_left_d;
    end
  end
`else
  logic unused_pad;
  assign unused_pad = ^{eou_flush_i, mid_frame, PadFrames};

  always_comb begin
    state_d    = S_WRITE;
    eou_done_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WRITE;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  // Count changes on the same edge that raises frame_done_o.
  assign frame_inc = advance && last_coef;
  assign frame_dec = rd_frame_release_i && (frame_count_q != '0);

  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_inc && !frame_dec) begin
      frame_count_d = frame_count_q + FcntWidth'(1);
    end else if (!frame_inc && frame_dec) begin
      frame_count_d = frame_count_q - FcntWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      eou_done_q    <= 1'b0;
    end else begin
      frame_count_q <= frame_count_d;
      wr_en_q       <= advance;
      wr_addr_q     <= advance ? addr : wr_addr_q;
      wr_data_q     <= accept ? cep_data_i : (pad_wr ? '0 : wr_data_q);
      frame_done_q  <= frame_inc;
      eou_done_q    <= eou_done_d;
    end
  end

  assign mem_wr_en_o   = wr_en_q;
  assign mem_wr_addr_o = wr_addr_q;
  assign mem_wr_data_o = wr_data_q;
  assign frame_done_o  = frame_done_q;
  assign frame_count_o = frame_count_q;
  assign eou_done_o    = eou_done_q;

endmodule

// File: tb/tb_cep_delta_ring_writer.sv
// Directed self-checking bench for cep_delta_ring_writer (13 coefs x 5 frames).
module tb_cep_delta_ring_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cep_valid = 1'b0;
  logic [15:0] cep_data = '0;
  logic        cep_ready;
  logic        rd_frame_release = 1'b0;
  logic        eou_flush = 1'b0;
  logic        mem_wr_en;
  logic [6:0]  mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        frame_done;
  logic [2:0]  frame_count;
  logic        full;
  logic        eou_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int eou_cnt = 0;

  logic [6:0]  log_addr[$];
  logic [15:0] log_data[$];
  logic        log_fd[$];
  logic        log_eou[$];
  logic [2:0]  log_fc[$];
  int          log_cyc[$];
  int          acc_cyc[$];

  cep_delta_ring_writer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cep_valid_i       (cep_valid),
    .cep_data_i        (cep_data),
    .cep_ready_o       (cep_ready),
    .rd_frame_release_i(rd_frame_release),
    .eou_flush_i       (eou_flush),
    .mem_wr_en_o       (mem_wr_en),
    .mem_wr_addr_o     (mem_wr_addr),
    .mem_wr_data_o     (mem_wr_data),
    .frame_done_o      (frame_done),
    .frame_count_o     (frame_count),
    .full_o            (full),
    .eou_done_o        (eou_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      log_addr.push_back(mem_wr_addr);
      log_data.push_back(mem_wr_data);
      log_fd.push_back(frame_done);
      log_eou.push_back(eou_done);
      log_fc.push_back(frame_count);
      log_cyc.push_back(cyc);
    end
    if (eou_done) eou_cnt = eou_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_fd.delete();
    log_eou.delete(); log_fc.delete(); log_cyc.delete(); acc_cyc.delete();
    eou_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cep_valid = 1'b0; rd_frame_release = 1'b0; eou_flush = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Entered and left on a falling edge.
  task automatic send(input logic [15:0] d);
    logic ok;
    ok = 1'b0;
    cep_valid = 1'b1;
    cep_data  = d;
    for (int t = 0; t < 64 && !ok; t++) begin
      #1 ok = cep_ready;
      @(negedge clk);
    end
    cep_valid = 1'b0;
    if (ok) acc_cyc.push_back(cyc);
    else chk("send_timeout", 0, 1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, cep_ready, 0);
    chk({tag, "_wr_en"}, mem_wr_en, 0);
    chk({tag, "_addr"}, mem_wr_addr, 0);
    chk({tag, "_data"}, mem_wr_data, 0);
    chk({tag, "_fdone"}, frame_done, 0);
    chk({tag, "_fcount"}, frame_count, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_eou"}, eou_done, 0);
  endtask

  initial begin
    int n;
    // ---- Reset state
    repeat (2) @(negedge clk);
    #1 chk_zero_outputs("rst");
    @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    @(negedge clk);

    // ---- T1: one frame back-to-back
    for (int i = 0; i < 13; i++) send(16'(i + 1));
    repeat (2) @(negedge clk);
    chk("t1_nwr", log_addr.size(), 13);
    for (int i = 0; i < 13 && i < log_addr.size(); i++) begin
      chk("t1_addr", log_addr[i], i);
      chk("t1_data", log_data[i], i + 1);
      chk("t1_fdone", log_fd[i], (i == 12) ? 1 : 0);
      chk("t1_fcnt_at_wr", log_fc[i], (i == 12) ? 1 : 0);
      chk("t1_latency", log_cyc[i], acc_cyc[i]);
    end
    chk("t1_fcount", frame_count, 1);

    // ---- T2: fill ring, then back-pressure until one release
    do_reset();
    for (int i = 0; i < 65; i++) send(16'(16'h0100 + i));
    repeat (2) @(negedge clk);
    chk("t2_fcount", frame_count, 5);
    chk("t2_full", full, 1);
    chk("t2_ready", cep_ready, 0);
    chk("t2_nwr", log_addr.size(), 65);
    n = 0;
    for (int i = 0; i < log_addr.size(); i++) begin
      chk("t2_addr", log_addr[i], i);
      chk("t2_data", log_data[i], 16'h0100 + i);
      if (log_fd[i]) n++;
    end
    chk("t2_nfdone", n, 5);
    cep_valid = 1'b1; cep_data = 16'h0ABC;
    repeat (4) @(negedge clk);
    #1 chk("t2_held_ready", cep_ready, 0);
    chk("t2_held_nwr", log_addr.size(), 65);
    @(negedge clk);
    rd_frame_release = 1'b1;
    @(negedge clk);
    rd_frame_release = 1'b0;
    #1 chk("t2_rel_fcount", frame_count, 4);
    chk("t2_rel_ready", cep_ready, 1);
    @(negedge clk);
    cep_valid = 1'b0;
    @(negedge clk);
    chk("t2_66_nwr", log_addr.size(), 66);
    if (log_addr.size() == 66) begin
      chk("t2_66_addr", log_addr[65], 0);
      chk("t2_66_data", log_data[65], 16'h0ABC);
    end

    // ---- T3: release at count 0, then 7 frames with releases coincident
    do_reset();
    rd_frame_release = 1'b1;
    @(negedge clk);
    rd_frame_release = 1'b0;
    @(negedge clk);
    chk("t3_rel0_fcount", frame_count, 0);
    for (int f = 0; f < 7; f++) begin
      for (int c = 0; c < 13; c++) begin
        if (c == 12 && f > 0) rd_frame_release = 1'b1;
        send(16'(16'h0200 + f * 13 + c));
        rd_frame_release = 1'b0;
      end
      chk("t3_fcount", frame_count, 1);
    end
    @(negedge clk);
    chk("t3_nwr", log_addr.size(), 91);
    n = 0;
    for (int i = 0; i < log_addr.size(); i++) begin
      chk("t3_addr", log_addr[i], i % 65);
      chk("t3_data", log_data[i], 16'h0200 + i);
      if (log_fd[i]) n++;
    end
    chk("t3_nfdone", n, 7);
    rd_frame_release = 1'b1;
    @(negedge clk);
    rd_frame_release = 1'b0;
    @(negedge clk);
    chk("t3_rel_fcount", frame_count, 0);

    // ---- T4: valid gaps, reset at coefficient 6 of frame 2
    do_reset();
    for (int i = 0; i < 32; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(16'(16'h0300 + i));
    end
    @(negedge clk);
    chk("t4_nwr", log_addr.size(), 32);
    for (int i = 0; i < log_addr.size(); i++) begin
      chk("t4_addr", log_addr[i], i % 65);
      chk("t4_data", log_data[i], 16'h0300 + i);
    end
    chk("t4_fcount_pre", frame_count, 2);
    rst_n = 1'b0;
    #1 chk_zero_outputs("t4_rst");
    @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    @(negedge clk);
    send(16'hBEEF);
    @(negedge clk);
    chk("t4_post_nwr", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      chk("t4_post_addr", log_addr[0], 0);
      chk("t4_post_data", log_data[0], 16'hBEEF);
    end
    chk("t4_post_fcount", frame_count, 0);

    // ---- T5: end-of-utterance flush after 20 coefficients
    do_reset();
    for (int i = 0; i < 20; i++) send(16'(16'h0400 + i));
    eou_flush = 1'b1;
    @(negedge clk);
    eou_flush = 1'b0;
`ifdef CEP_DELTA_PAD_EN
    #1 chk("t5_pad_ready", cep_ready, 0);
`endif
    repeat (3) @(negedge clk);
    eou_flush = 1'b1;  // ignored while padding
    @(negedge clk);
    eou_flush = 1'b0;
    repeat (40) @(negedge clk);
`ifdef CEP_DELTA_PAD_EN
    chk("t5_nwr", log_addr.size(), 52);
    for (int i = 20; i < log_addr.size(); i++) begin
      chk("t5_pad_addr", log_addr[i], i);
      chk("t5_pad_data", log_data[i], 0);
      chk("t5_pad_eou", log_eou[i], (i == 51) ? 1 : 0);
      chk("t5_pad_fdone", log_fd[i], (i == 25 || i == 38 || i == 51) ? 1 : 0);
    end
    chk("t5_eou_cnt", eou_cnt, 1);
    chk("t5_fcount", frame_count, 4);
    chk("t5_ready_after", cep_ready, 1);
`else
    chk("t5_nwr", log_addr.size(), 20);
    chk("t5_eou_cnt", eou_cnt, 0);
    chk("t5_fcount", frame_count, 1);
    chk("t5_ready", cep_ready, 1);
`endif
    for (int i = 0; i < 20 && i < log_addr.size(); i++) begin
      chk("t5_addr", log_addr[i], i);
      chk("t5_data", log_data[i], 16'h0400 + i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
